// File: rtl/line_buffer_ctrl.sv
// Sequencer for a 3x3 window line buffer: FILL primes the row FIFOs, STREAM emits one window per
// accepted pixel, FLUSH drains the last rows with zero padding. Define LB_CTRL_BORDER_SKIP_EN to emit interior windows only.
module line_buffer_ctrl #(
  parameter int IMG_WIDTH   = 64,
  parameter int IMG_HEIGHT  = 48,
  parameter int COORD_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   lb_shift,
  output logic                   pad_en,
  output logic [COORD_WIDTH-1:0] win_row,
  output logic [COORD_WIDTH-1:0] win_col,
  output logic                   border_flag,
  output logic                   frame_done
);

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  localparam int                     FILL_W    = $clog2(IMG_WIDTH + 2);
  localparam logic [FILL_W-1:0]      FILL_LAST = FILL_W'(IMG_WIDTH);
  localparam logic [COORD_WIDTH-1:0] C_ZERO    = COORD_WIDTH'(0);
  localparam logic [COORD_WIDTH-1:0] C_ONE     = COORD_WIDTH'(1);
  localparam logic [COORD_WIDTH-1:0] COL_LAST  = COORD_WIDTH'(IMG_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] ROW_LAST  = COORD_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [COORD_WIDTH-1:0] COL_PRE   = COORD_WIDTH'(IMG_WIDTH - 2);
  localparam logic [COORD_WIDTH-1:0] ROW_PRE   = COORD_WIDTH'(IMG_HEIGHT - 2);

`ifdef LB_CTRL_BORDER_SKIP_EN
  localparam logic SKIP_BORDER = 1'b1;
`else
  localparam logic SKIP_BORDER = 1'b0;
`endif

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;
  logic                   r_run;
  logic [FILL_W-1:0]      r_fill_cnt;
  logic [COORD_WIDTH-1:0] r_cen_row;
  logic [COORD_WIDTH-1:0] r_cen_col;
  logic                   r_flush_done;
  logic                   r_m_valid;
  logic                   r_border;
  logic                   r_last;
  logic [COORD_WIDTH-1:0] r_win_row;
  logic [COORD_WIDTH-1:0] r_win_col;

  logic w_out_free;
  logic w_s_ready;
  logic w_shift;
  logic w_win_gen;
  logic w_emit;
  logic w_cen_border;
  logic w_cen_pre_last;
  logic w_cen_final;
  logic w_last_win;

  // r_cen_* is the center of the window the next shift will produce
  assign w_out_free     = !r_m_valid || m_ready;
  assign w_cen_border   = (r_cen_row == C_ZERO) || (r_cen_row == ROW_LAST) ||
                          (r_cen_col == C_ZERO) || (r_cen_col == COL_LAST);
  assign w_cen_pre_last = (r_cen_row == ROW_PRE) && (r_cen_col == COL_PRE);
  assign w_cen_final    = (r_cen_row == ROW_LAST) && (r_cen_col == COL_LAST);
  assign w_emit         = w_win_gen && !(SKIP_BORDER && w_cen_border);
  assign w_last_win     = SKIP_BORDER ? w_cen_pre_last : w_cen_final;

  assign s_ready     = w_s_ready;
  assign lb_shift    = w_shift;
  assign pad_en      = (r_state == ST_FLUSH);
  assign m_valid     = r_m_valid;
  assign win_row     = r_win_row;
  assign win_col     = r_win_col;
  assign border_flag = r_border;
  assign frame_done  = r_m_valid && m_ready && r_last;

  // Next-state, ready and shift decode
  always_comb begin
    w_next_state = r_state;
    w_s_ready    = 1'b0;
    w_shift      = 1'b0;
    w_win_gen    = 1'b0;
    case (r_state)
      ST_FILL: begin
        w_s_ready = r_run;
        w_shift   = s_valid && r_run;
        if (w_shift && (r_fill_cnt == FILL_LAST)) w_next_state = ST_STREAM;
        else                                      w_next_state = ST_FILL;
      end
      ST_STREAM: begin
        w_s_ready = w_out_free;
        w_shift   = s_valid && w_out_free;
        w_win_gen = w_shift;
        if (w_shift && w_cen_pre_last) w_next_state = ST_FLUSH;
        else                           w_next_state = ST_STREAM;
      end
      ST_FLUSH: begin
        w_shift   = !r_flush_done && w_out_free;
        w_win_gen = w_shift;
        // leave only once the final window has left the output register
        if (r_flush_done && w_out_free) w_next_state = ST_FILL;
        else                            w_next_state = ST_FLUSH;
      end
      default: w_next_state = ST_FILL;
    endcase
  end

  // State register; r_run holds s_ready low until the first edge after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_FILL;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_run   <= 1'b1;
    end
  end

  // Priming pixel counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_fill_cnt <= FILL_W'(0);
    else if (r_state != ST_FILL) r_fill_cnt <= FILL_W'(0);
    else if (w_shift)           r_fill_cnt <= r_fill_cnt + FILL_W'(1);
    else                        r_fill_cnt <= r_fill_cnt;
  end

  // Raster center counter, advanced by every window-producing shift
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cen_row <= C_ZERO;
      r_cen_col <= C_ZERO;
    end else if (w_win_gen) begin
      if (r_cen_col == COL_LAST) begin
        r_cen_col <= C_ZERO;
        r_cen_row <= (r_cen_row == ROW_LAST) ? C_ZERO : r_cen_row + C_ONE;
      end else begin
        r_cen_col <= r_cen_col + C_ONE;
      end
    end
  end

  // Marks that the last flush shift has been issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_flush_done <= 1'b0;
    else if (r_state != ST_FLUSH)      r_flush_done <= 1'b0;
    else if (w_win_gen && w_cen_final) r_flush_done <= 1'b1;
    else                               r_flush_done <= r_flush_done;
  end

  // Output window register: loads on emit, clears on handshake, holds while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_m_valid <= 1'b0;
      r_win_row <= C_ZERO;
      r_win_col <= C_ZERO;
      r_border  <= 1'b0;
      r_last    <= 1'b0;
    end else if (w_emit) begin
      r_m_valid <= 1'b1;
      r_win_row <= r_cen_row;
      r_win_col <= r_cen_col;
      r_border  <= w_cen_border && !SKIP_BORDER;
      r_last    <= w_last_win;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

endmodule

// File: doc/line_buffer_ctrl.md
LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 64: pixels per row; legal range 3 or more.
REQ-002 SHALL have parameter IMG_HEIGHT, default 48: rows per frame; legal range 3 or more.
REQ-003 SHALL have parameter COORD_WIDTH, default 12: width of the coordinate outputs; must hold max(IMG_WIDTH, IMG_HEIGHT)-1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic samples on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port s_valid, input, 1 bit: the upstream pixel source holds a pixel.
REQ-007 SHALL have port s_ready, output, 1 bit: the controller accepts a pixel this cycle.
REQ-008 SHALL have port m_valid, output, 1 bit: a 3x3 window is valid at the row FIFOs/window registers.
REQ-009 SHALL have port m_ready, input, 1 bit: downstream (gradient stage) takes the window.
REQ-010 SHALL have port lb_shift, output, 1 bit: advance enable for the row-FIFO cascade and the window shift registers.
REQ-011 SHALL have port pad_en, output, 1 bit: line-buffer input is forced to zero during flush shifts.
REQ-012 SHALL have port win_row, output, COORD_WIDTH bits: row of the window center.
REQ-013 SHALL have port win_col, output, COORD_WIDTH bits: column of the window center.
REQ-014 SHALL have port border_flag, output, 1 bit: the window center lies on row 0, row IMG_HEIGHT-1, column 0 or column IMG_WIDTH-1.
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse on the handshake of the last window of a frame.

Function
REQ-016 SHALL implement an FSM with states FILL, STREAM and FLUSH.
REQ-017 In FILL, s_ready SHALL be 1, m_valid SHALL stay 0, and each s_valid&&s_ready SHALL pulse lb_shift.
- Transition to STREAM occurs after IMG_WIDTH+1 accepted pixels.
REQ-018 In STREAM, s_ready SHALL equal (!m_valid || m_ready).
- Each accept pulses lb_shift in the same cycle.
- On the next cycle, m_valid is set with the center coordinates (row/col of the accepted pixel minus (1,1), wrapped across the row boundary).
REQ-019 An m_valid&&m_ready handshake with no new accept SHALL clear m_valid on the next cycle; m_valid SHALL NOT drop without a handshake.
REQ-020 After the pixel at input index IMG_WIDTH*IMG_HEIGHT-1 is accepted, the FSM SHALL enter FLUSH.
REQ-021 In FLUSH, s_ready SHALL be 0 and pad_en SHALL be 1.
- The controller self-issues lb_shift whenever (!m_valid || m_ready), producing exactly IMG_WIDTH+1 further windows.
- It then returns to FILL for the next frame.
REQ-022 Total windows per frame SHALL equal IMG_WIDTH*IMG_HEIGHT, in raster order of center (0,0)..(IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-023 win_col SHALL wrap to 0 at IMG_WIDTH-1 and increment win_row; win_row SHALL wrap to 0 after IMG_HEIGHT-1.
REQ-024 border_flag, win_row and win_col SHALL be registered together with m_valid and held stable while m_valid&&!m_ready.
REQ-025 frame_done SHALL pulse only on the handshake of window (IMG_HEIGHT-1, IMG_WIDTH-1).
- The first FILL accept of the next frame can occur in the cycle after that pulse.
REQ-026 lb_shift SHALL never assert when a valid window is stalled (m_valid && !m_ready).

Reset
REQ-027 rst low SHALL asynchronously force state FILL and clear all counters.
- Outputs take these values: s_ready=0 while in reset and 1 from the first cycle after release; m_valid=0, lb_shift=0, pad_en=0, win_row=0, win_col=0, border_flag=0, frame_done=0.
REQ-028 Reset mid-frame SHALL discard partial-frame state; line-buffer contents are don't-care and are overwritten by the next FILL.

Configuration
REQ-029 Macro LB_CTRL_BORDER_SKIP_EN, when defined, SHALL suppress m_valid for windows whose center is on a border.
- Shifts still occur and stall-free advance continues.
- The frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows, and border_flag is tied 0.
- frame_done pulses on the handshake of the last interior window (IMG_HEIGHT-2, IMG_WIDTH-2).
REQ-030 Without LB_CTRL_BORDER_SKIP_EN, all IMG_WIDTH*IMG_HEIGHT windows SHALL be emitted, with border_flag as in REQ-014.

Verification
REQ-031 Bench SHALL use IMG_WIDTH=4 and IMG_HEIGHT=3, with s_valid=1 and m_ready=1 continuously.
- Required response: first m_valid 6 cycles after the first accept, center (0,0) with border_flag=1.
- 12 windows in total, frame_done on (2,3).
REQ-032 Bench SHALL drop m_ready for 5 cycles mid-STREAM.
- Required response: s_ready=0 and lb_shift=0 during the stall; win_row/win_col held; no window lost or duplicated.
REQ-033 Bench SHALL drop s_valid for 5 cycles in FILL and in STREAM.
- Required response: no lb_shift; m_valid clears after handshake; the coordinate sequence continues unbroken.
REQ-034 Bench SHALL stall m_ready during FLUSH.
- Required response: pad_en=1, s_ready=0; exactly 5 flush windows; next frame starts in FILL.
REQ-035 Bench SHALL assert rst low mid-STREAM (after 8 accepts).
- Required response: all outputs take reset values immediately; the next frame restarts at center (0,0).
REQ-036 Bench SHALL repeat REQ-031 with LB_CTRL_BORDER_SKIP_EN defined.
- Required response: exactly 2 windows, centers (1,1) and (1,2); frame_done on (1,2).
